// File: rtl/gpio8_irq_ctrl.sv
// Per-pin event select into sticky raw status, masked summary, and a single
// interrupt line with a programmable low gap between assertions.
module gpio8_irq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pin_hi,
  input  logic [7:0]       pin_lo,
  input  logic [7:0]       pin_pe,
  input  logic [7:0]       pin_ne,
  input  logic             mode_wr,
  input  logic [15:0]      mode_wdata,
  input  logic             im_wr,
  input  logic [7:0]       im_wdata,
  input  logic             icr_wr,
  input  logic [7:0]       icr_wdata,
  input  logic [CNT_W-1:0] holdoff,
  output logic [15:0]      mode,
  output logic [7:0]       im,
  output logic [7:0]       ris,
  output logic [7:0]       mis,
  output logic             irq,
  output logic             pend_valid,
  output logic [2:0]       pend_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       sel;
  logic [7:0]       clr;
  logic             irq_nxt;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    sel = 8'h00;
    for (int i = 0; i < 8; i++) begin
      unique case (mode[2*i +: 2])
        2'b00:   sel[i] = pin_hi[i];
        2'b01:   sel[i] = pin_lo[i];
        2'b10:   sel[i] = pin_pe[i];
        default: sel[i] = pin_ne[i];
      endcase
    end
  end

  assign clr        = {8{icr_wr}} & icr_wdata;
  assign mis        = ris & im;
  assign pend_valid = |mis;
  assign pend_id    = lowest_set(mis);

  // Clearing the last masked bit or masking it away both leave ASSERT here.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (mis != 8'h00) state_nxt = S_ASSERT;
      end
      S_ASSERT: begin
        if (mis == 8'h00) begin
          if (holdoff == '0) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt   = holdoff;
            state_nxt = S_HOLDOFF;
          end
        end
      end
      S_HOLDOFF: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
    irq_nxt = (state_nxt == S_ASSERT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode  <= 16'hAAAA;
      im    <= 8'h00;
      ris   <= 8'h00;
      state <= S_IDLE;
      cnt   <= '0;
      irq   <= 1'b0;
    end else begin
      if (mode_wr) mode <= mode_wdata;
      if (im_wr)   im   <= im_wdata;
      // A new event in the same cycle as its clear keeps the bit set.
      ris   <= sel | (ris & ~clr);
      state <= state_nxt;
      cnt   <= cnt_nxt;
      irq   <= irq_nxt;
    end
  end

endmodule
